// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Round-robin arbiter/sequencer of ports A and B onto a single-port memory.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LOCK_MAX   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         a_req,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic                         a_we,
  input  logic signed [DATA_WIDTH-1:0] a_wdata,
  output logic                         a_gnt,
  output logic                         a_rvalid,
  output logic signed [DATA_WIDTH-1:0] a_rdata,
  input  logic                         b_req,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  input  logic                         b_we,
  input  logic signed [DATA_WIDTH-1:0] b_wdata,
  input  logic                         b_lock,
  output logic                         b_gnt,
  output logic                         b_rvalid,
  output logic signed [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic signed [DATA_WIDTH-1:0] mem_data,
  output logic                         mem_we,
  input  logic signed [DATA_WIDTH-1:0] mem_q
);

  localparam int unsigned             c_cnt_w    = $clog2(LOCK_MAX + 1);
  localparam logic [c_cnt_w-1:0]      c_lock_max = c_cnt_w'(LOCK_MAX);

  logic                         a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                         a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic signed [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
  logic signed [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                         mem_we_q, mem_we_d;
  logic                         last_b_q, last_b_d;
  logic [c_cnt_w-1:0]           lock_cnt_q, lock_cnt_d;

  logic w_lock_active, w_a_elig, w_b_elig, w_grant_a, w_grant_b;

  // A port whose grant is still showing is skipped so a held request is not served twice.
  assign w_lock_active = b_lock && b_req && (lock_cnt_q < c_lock_max);
  assign w_a_elig      = a_req && !a_gnt_q && !w_lock_active;
  assign w_b_elig      = b_req && !b_gnt_q;
  assign w_grant_a     = w_a_elig && (!w_b_elig || last_b_q);
  assign w_grant_b     = w_b_elig && (!w_a_elig || !last_b_q);

  always_comb begin
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    last_b_d   = last_b_q;
    lock_cnt_d = lock_cnt_q;

    // mem_we_q still describes the access that is on the bus this cycle.
    if (a_gnt_q && !mem_we_q) begin
      a_rvalid_d = 1'b1;
      a_rdata_d  = mem_q;
    end
    if (b_gnt_q && !mem_we_q) begin
      b_rvalid_d = 1'b1;
      b_rdata_d  = mem_q;
    end

    if (w_grant_a) begin
      a_gnt_d    = 1'b1;
      mem_addr_d = a_addr;
      mem_data_d = a_wdata;
      mem_we_d   = a_we;
      last_b_d   = 1'b0;
    end else if (w_grant_b) begin
      b_gnt_d    = 1'b1;
      mem_addr_d = b_addr;
      mem_data_d = b_wdata;
      mem_we_d   = b_we;
      last_b_d   = 1'b1;
    end

    if (!b_lock) begin
      lock_cnt_d = '0;
    end else if (w_grant_b && w_lock_active) begin
      lock_cnt_d = lock_cnt_q + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      last_b_q   <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      last_b_q   <= last_b_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                        |
// | Directed and randomized self-checking bench for mem_port_arbiter.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int c_lock_max = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic        [15:0] a_addr = '0, b_addr = '0;
  logic signed [15:0] a_wdata = '0, b_wdata = '0;
  logic               a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;
  logic signed [15:0] a_rdata, b_rdata, mem_data, mem_q;
  logic        [15:0] mem_addr;

  mem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .LOCK_MAX(c_lock_max)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Memory environment: combinational read, write commit on the falling edge.
  logic [15:0] ram     [0:65535];
  logic [15:0] ref_ram [0:65535];
  assign mem_q = ram[mem_addr];
  always @(negedge clk) if (mem_we) ram[mem_addr] <= mem_data;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endfunction

  // Reference model: who owns the bus this cycle and what each port sees.
  int          bus_who = 0;      // 0 none, 1 A, 2 B
  logic [15:0] bus_addr = '0, bus_data = '0;
  logic        bus_we = 1'b0;
  logic        rv_a = 1'b0, rv_b = 1'b0;
  logic [15:0] rd_a = '0, rd_b = '0;
  bit          last_was_b = 1'b1;
  int          locked = 0;

  always @(posedge clk) begin
    bit lock_on, want_a, want_b;
    int win;
    if (bus_who != 0 && bus_we) ref_ram[bus_addr] = bus_data;
    if (reset) begin
      bus_who = 0; bus_addr = '0; bus_data = '0; bus_we = 1'b0;
      rv_a = 1'b0; rv_b = 1'b0; rd_a = '0; rd_b = '0;
      last_was_b = 1'b1; locked = 0;
    end else begin
      rv_a = (bus_who == 1) && !bus_we;
      rv_b = (bus_who == 2) && !bus_we;
      if (rv_a) rd_a = ref_ram[bus_addr];
      if (rv_b) rd_b = ref_ram[bus_addr];
      lock_on = b_lock && b_req && (locked < c_lock_max);
      want_a  = a_req && (bus_who != 1) && !lock_on;
      want_b  = b_req && (bus_who != 2);
      if (want_a && want_b) win = last_was_b ? 1 : 2;
      else if (want_a)      win = 1;
      else if (want_b)      win = 2;
      else                  win = 0;
      if (!b_lock) locked = 0;
      else if (win == 2 && lock_on) locked++;
      bus_who = win;
      bus_we  = 1'b0;
      if (win == 1) begin bus_addr = a_addr; bus_data = a_wdata; bus_we = a_we; end
      if (win == 2) begin bus_addr = b_addr; bus_data = b_wdata; bus_we = b_we; end
      if (win != 0) last_was_b = (win == 2);
    end
  end

  always @(negedge clk) begin
    chk("a_gnt",    16'(a_gnt),    16'(bus_who == 1));
    chk("b_gnt",    16'(b_gnt),    16'(bus_who == 2));
    chk("gnt_excl", 16'(a_gnt & b_gnt), 16'd0);
    chk("mem_we",   16'(mem_we),   16'(bus_who != 0 && bus_we));
    chk("mem_addr", mem_addr,      bus_addr);
    chk("mem_data", mem_data,      bus_data);
    chk("a_rvalid", 16'(a_rvalid), 16'(rv_a));
    chk("b_rvalid", 16'(b_rvalid), 16'(rv_b));
    chk("a_rdata",  a_rdata,       rd_a);
    chk("b_rdata",  b_rdata,       rd_b);
  end

  // sel: 0 a_gnt, 1 b_gnt, 2 a_rvalid, 3 b_rvalid
  task automatic wait_for(input int sel, input string nm, output int n);
    bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < 20) begin
      @(negedge clk);
      n++;
      case (sel)
        0: hit = a_gnt;
        1: hit = b_gnt;
        2: hit = a_rvalid;
        default: hit = b_rvalid;
      endcase
    end
    chk(nm, 16'(hit), 16'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1; a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    int n, cnt;
    bit seen;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'(i) ^ 16'h5A5A;
      ref_ram[i] = ram[i];
    end
    ram[16'h0010] = 16'h1234; ref_ram[16'h0010] = 16'h1234;
    ram[16'h6000] = 16'h00FF; ref_ram[16'h6000] = 16'h00FF;

    repeat (3) @(negedge clk);
    chk("rst_a_gnt", 16'(a_gnt), 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_a_rdata", a_rdata, 16'h0000);
    reset = 1'b0;

    // A read alone
    @(negedge clk); a_req = 1'b1; a_addr = 16'h0010; a_we = 1'b0;
    wait_for(0, "t1_a_gnt", n);
    chk("t1_gnt_latency", 16'(n), 16'd1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    chk("t1_mem_we", 16'(mem_we), 16'd0);
    a_req = 1'b0;
    @(negedge clk);
    chk("t1_a_rvalid", 16'(a_rvalid), 16'd1);
    chk("t1_a_rdata", a_rdata, 16'h1234);

    // Simultaneous requests after reset
    pulse_reset();
    a_req = 1'b1; a_addr = 16'h0020; a_we = 1'b0;
    b_req = 1'b1; b_addr = 16'h0030; b_we = 1'b1; b_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t2_a_first", 16'(a_gnt), 16'd1);
    chk("t2_a_addr", mem_addr, 16'h0020);
    a_req = 1'b0;
    @(negedge clk);
    chk("t2_b_second", 16'(b_gnt), 16'd1);
    chk("t2_b_we", 16'(mem_we), 16'd1);
    chk("t2_b_data", mem_data, 16'hBEEF);
    b_req = 1'b0;
    a_req = 1'b1; a_addr = 16'h0030; a_we = 1'b0;
    wait_for(0, "t2_rd_gnt", n);
    a_req = 1'b0;
    wait_for(2, "t2_rd_rvalid", n);
    chk("t2_rd_data", a_rdata, 16'hBEEF);

    // Both held continuously: strict alternation starting with A
    pulse_reset();
    a_req = 1'b1; a_addr = 16'h0001; a_we = 1'b0;
    b_req = 1'b1; b_addr = 16'h0002; b_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_a_gnt", 16'(a_gnt), 16'(i % 2 == 0));
      chk("alt_b_gnt", 16'(b_gnt), 16'(i % 2 == 1));
    end
    a_req = 1'b0; b_req = 1'b0;

    // Bounded lock, twice: second round shows the counter cleared
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      b_lock = 1'b1; b_req = 1'b1; b_addr = 16'h0040; b_we = 1'b1; b_wdata = 16'h1111;
      a_req = 1'b1; a_addr = 16'h0041; a_we = 1'b0;
      cnt = 0; seen = 1'b0; n = 0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        if (b_gnt) cnt++;
        if (a_gnt) seen = 1'b1;
      end
      chk("lock_a_granted", 16'(seen), 16'd1);
      chk("lock_b_grants", 16'(cnt), 16'(c_lock_max));
      a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
      @(negedge clk);
    end

    // I/O pass-through
    b_req = 1'b1; b_addr = 16'h6000; b_we = 1'b0;
    wait_for(1, "io_rd_gnt", n);
    b_req = 1'b0;
    wait_for(3, "io_rd_rvalid", n);
    chk("io_rd_data", b_rdata, 16'h00FF);
    b_req = 1'b1; b_addr = 16'h6001; b_we = 1'b1; b_wdata = 16'h0042;
    wait_for(1, "io_wr_gnt", n);
    chk("io_wr_addr", mem_addr, 16'h6001);
    chk("io_wr_we", 16'(mem_we), 16'd1);
    b_req = 1'b0;
    @(negedge clk);
    chk("io_wr_we_drop", 16'(mem_we), 16'd0);

    // Reset at the edge ending A's read grant
    a_req = 1'b1; a_addr = 16'h0010; a_we = 1'b0;
    wait_for(0, "rst_rd_gnt", n);
    a_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_rd_rvalid", 16'(a_rvalid), 16'd0);
    chk("rst_rd_rdata", a_rdata, 16'h0000);
    chk("rst_rd_addr", mem_addr, 16'h0000);
    reset = 1'b0;
    a_req = 1'b1; a_addr = 16'h0003; b_req = 1'b1; b_addr = 16'h0004; b_we = 1'b0;
    @(negedge clk);
    chk("rst_tie_a", 16'(a_gnt), 16'd1);
    chk("rst_tie_b", 16'(b_gnt), 16'd0);
    a_req = 1'b0; b_req = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (a_req && a_gnt) a_req = 1'b0;
      else if (a_req && $urandom_range(0, 99) < 4) a_req = 1'b0;
      else if (!a_req && $urandom_range(0, 99) < 50) begin
        a_req = 1'b1; a_addr = 16'($urandom_range(0, 15));
        a_we = 1'($urandom_range(0, 1)); a_wdata = 16'($urandom);
      end
      if (b_req && b_gnt) b_req = 1'b0;
      else if (b_req && $urandom_range(0, 99) < 4) b_req = 1'b0;
      else if (!b_req && $urandom_range(0, 99) < 50) begin
        b_req = 1'b1; b_addr = 16'($urandom_range(0, 15));
        b_we = 1'($urandom_range(0, 1)); b_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 99) < 8) b_lock = ~b_lock;
    end
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0; reset = 1'b0;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the shared single-port data memory. It sits between the CPU instruction-fetch port (A) and the load/store port (B) on one side and the memory's `addr`/`data`/`we`/`q` on the other. It serialises accesses with round-robin fairness and registers all memory-side controls. It also supports a bounded bus lock on port B for read-modify-write sequences. Memory-mapped I/O addresses pass through unchanged; the memory decodes them itself.

## Interface
- `DATA_WIDTH`, 16, width of data words.
- `ADDR_WIDTH`, 16, width of addresses.
- `LOCK_MAX`, 4, maximum consecutive B grants while `b_lock` is held. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock, rising-edge logic. The memory itself acts on the falling edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_req`  in  1  port A access request. Held with `a_addr`/`a_we`/`a_wdata` stable until `a_gnt` is seen.
- `a_addr`  in  ADDR_WIDTH  port A address.
- `a_we`  in  1  port A write enable (1 = write, 0 = read).
- `a_wdata`  in  DATA_WIDTH signed  port A write data.
- `a_gnt`  out  1  one-cycle pulse; A's access is on the memory bus this cycle.
- `a_rvalid`  out  1  one-cycle pulse; `a_rdata` holds A's read result.
- `a_rdata`  out  DATA_WIDTH signed  A read data. Holds until A's next read completes.
- `b_req`, `b_addr`, `b_we`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`  same meanings for port B.
- `b_lock`  in  1  while high with `b_req`, port A is excluded from arbitration.
- `mem_addr`  out  ADDR_WIDTH  registered address to memory.
- `mem_data`  out  DATA_WIDTH signed  registered write data to memory.
- `mem_we`  out  1  registered write enable to memory.
- `mem_q`  in  DATA_WIDTH signed  memory read data. Valid in the second half of the cycle its address is driven.

## Operation
- **Arbitration** runs at every rising edge on sampled requests.
  - A requester whose `gnt` is currently high is ineligible at that edge. This prevents double-granting a held request.
- **Eligible set:**
  - A is eligible when `a_req=1`, `a_gnt=0`, and the lock is not active.
  - B is eligible when `b_req=1` and `b_gnt=0`.
- **Lock:**
  - The lock is active when `b_lock=1`, `b_req=1`, and `lock_cnt < LOCK_MAX`.
  - `lock_cnt` increments on each B grant issued while the lock is active.
  - `lock_cnt` clears whenever `b_lock=0`.
  - When `lock_cnt` reaches `LOCK_MAX`, the lock is ignored and normal round-robin resumes until `b_lock` drops.
- **Selection:**
  - One eligible requester: it is granted.
  - Both eligible: the one not granted most recently wins.
  - `last_grant` updates on every grant.
- **Grant:**
  - Registers `gnt`=1 for exactly one cycle.
  - Registers `mem_addr`, `mem_data`, `mem_we` from the winner's inputs.
- **No grant:** `mem_we`=0; `mem_addr` and `mem_data` hold their previous values.
- **Read completion:** at the rising edge ending a read grant cycle, `mem_q` is captured into that port's `rdata` and its `rvalid` is registered high for one cycle.
- **Write completion:** writes produce no `rvalid`. The memory commits the write on the falling edge inside the grant cycle.
- `a_gnt` and `b_gnt` are never high simultaneously.

## Timing
- **Reset values:**
  - `a_gnt`, `b_gnt`, `a_rvalid`, `b_rvalid`, `mem_we` = 0.
  - `mem_addr`, `mem_data`, `a_rdata`, `b_rdata` = 0.
  - `last_grant` = B, so A wins the first tie.
  - `lock_cnt` = 0.
- **Latency:** `req` sampled at edge k → `gnt` high and memory bus driven in cycle k..k+1 → `rvalid`/`rdata` in cycle k+1..k+2.
  - Minimum read latency: 2 cycles from request sample to data.
- **Throughput:**
  - One requester alone gets at most one access per 2 cycles.
  - Two requesters alternating keep the memory busy every cycle.
- **Reset mid-operation:**
  - Reset sampled at the edge ending a grant cycle suppresses that access's `rvalid`, and `rdata` goes to 0.
  - A write in that grant cycle has already committed at the falling edge.
- **Requester protocol:** deasserting `req` before `gnt` withdraws the request with no side effects. Changing the address while waiting is a protocol error and the result is undefined.

## Test plan
- **A read alone:** `a_req` with `a_addr`=0x0010 (memory holds 0x1234) sampled at edge 1 → `a_gnt` in cycle 1–2, `mem_addr`=0x0010, `mem_we`=0 → `a_rvalid`=1 with `a_rdata`=0x1234 in cycle 2–3.
- **Simultaneous requests after reset:** A read 0x0020 and B write 0x0030←0xBEEF → A granted first, B next cycle with `mem_we`=1, `mem_data`=0xBEEF. A subsequent read of 0x0030 returns 0xBEEF.
- **Both held continuously for 8 cycles:** grants alternate A,B,A,B…, one per cycle, never both high.
- **Lock:** `LOCK_MAX`=4, `b_lock`=1, `b_req` and `a_req` both held → exactly 4 B grants with no A grant in between, then A granted. Dropping `b_lock` clears `lock_cnt`.
- **I/O pass-through:** B read at 0x6000 with the memory's input port driven to 0x00FF → `b_rdata`=0x00FF. B write to 0x6001 with 0x0042 → `mem_addr`=0x6001, `mem_we`=1 for one cycle.
- **Reset mid-read:** reset asserted at the edge ending A's grant cycle → no `a_rvalid`, all outputs at reset values the next cycle, A wins the next tie.
